// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: per-digit data/attributes in, segment/enable pins out.
// Latency: n/a (wiring only).
// Backpressure: none; load is a single-cycle strobe, outputs are free-running.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   blink;
  logic                load;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   dig_en;
  logic                frame_tick;

  // Host side: drives data and load, observes the pins.
  modport master (
    output value, dp, blank, blink, load,
    input  seg, seg_dp, dig_en, frame_tick
  );

  // Driver side: consumes data, drives the pins.
  modport slave (
    input  value, dp, blank, blink, load,
    output seg, seg_dp, dig_en, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with hex decode, dp/blank/blink and tear-free frame updates.
// Latency: all outputs registered; loaded data shows from 1 cycle up to one frame + DEAD cycles later.
// Backpressure: none; load is always accepted, last load in a frame wins.
module seven_seg_scan #(
  parameter int CLK_HZ         = 48_000_000,
  parameter int DIGITS         = 4,
  parameter int SCAN_HZ        = 1000,
  parameter int DEAD           = 2,
  parameter int BLINK_HZ       = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  seven_seg_scan_if.slave disp
);

  localparam int DWELL    = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int SW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW > 1) ? HALF_RAW : 1;
  localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [SW-1:0] DEAD_C     = SW'(DEAD);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(DWELL - 1);
  localparam logic [IW-1:0] LAST_DIG   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(HALF - 1);

  // Inactive pin levels; XOR with these turns an active-high pattern into pin polarity.
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{EN_ACTIVE_LOW}};

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_scan: DIGITS must be 1..8");
  end
  if (DWELL < DEAD + 1) begin : g_bad_dwell
    $error("seven_seg_scan: slot too short for the dead time");
  end

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
  } disp_t;

  // Display stays dark until the first load.
  localparam disp_t DISP_RST = '{value: '0, dp: '0, blank: '1, blink: '0};

  typedef enum logic {ST_DARK, ST_ON} state_t;

  disp_t               in_data;
  disp_t               shadow;
  disp_t               active;
  logic                pending;

  logic [SW-1:0]       slot_cnt;
  logic [SW-1:0]       slot_nxt;
  logic [IW-1:0]       dig_idx;
  logic                slot_last;
  logic                frame_last;
  state_t              state;

  logic [BW-1:0]       blink_cnt;
  logic                blink_req;
  logic                blink_phase;

  logic [3:0]          cur_nib;
  logic                cur_dark;
  logic [6:0]          seg_on;
  logic                dp_on;
  logic [DIGITS-1:0]   en_on;

  logic [6:0]          seg_q;
  logic                seg_dp_q;
  logic [DIGITS-1:0]   dig_en_q;
  logic                frame_tick_q;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0:    hex_font = 7'h3F;
      4'h1:    hex_font = 7'h06;
      4'h2:    hex_font = 7'h5B;
      4'h3:    hex_font = 7'h4F;
      4'h4:    hex_font = 7'h66;
      4'h5:    hex_font = 7'h6D;
      4'h6:    hex_font = 7'h7D;
      4'h7:    hex_font = 7'h07;
      4'h8:    hex_font = 7'h7F;
      4'h9:    hex_font = 7'h6F;
      4'hA:    hex_font = 7'h77;
      4'hB:    hex_font = 7'h7C;
      4'hC:    hex_font = 7'h39;
      4'hD:    hex_font = 7'h5E;
      4'hE:    hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  assign in_data    = {disp.value, disp.dp, disp.blank, disp.blink};
  assign slot_last  = (slot_cnt == LAST_SLOT);
  assign frame_last = slot_last && (dig_idx == LAST_DIG);
  assign slot_nxt   = slot_last ? '0 : slot_cnt + SW'(1);

  // Pin patterns for the digit currently being scanned, already in output polarity.
  always_comb begin
    cur_nib  = active.value[{dig_idx, 2'b00} +: 4];
    cur_dark = active.blank[dig_idx] | (active.blink[dig_idx] & blink_phase);
    seg_on   = cur_dark ? SEG_OFF : (hex_font(cur_nib) ^ SEG_OFF);
    dp_on    = (active.dp[dig_idx] & ~cur_dark) ^ DP_OFF;
    en_on    = (DIGITS'(1) << dig_idx) ^ EN_OFF;
  end

  // Scan counters and the DARK/ON slot FSM; the state names the phase of the cycle being output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt     <= '0;
      dig_idx      <= '0;
      state        <= (DEAD == 0) ? ST_ON : ST_DARK;
      seg_q        <= SEG_OFF;
      seg_dp_q     <= DP_OFF;
      dig_en_q     <= EN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt     <= slot_nxt;
      if (slot_last) begin
        dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + IW'(1);
      end
      state        <= (slot_nxt < DEAD_C) ? ST_DARK : ST_ON;
      frame_tick_q <= frame_last;
      case (state)
        ST_ON: begin
          seg_q    <= seg_on;
          seg_dp_q <= dp_on;
          dig_en_q <= en_on;
        end
        default: begin
          seg_q    <= SEG_OFF;
          seg_dp_q <= DP_OFF;
          dig_en_q <= EN_OFF;
        end
      endcase
    end
  end

  // Input -> shadow -> active; active only changes on the last cycle of a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow  <= DISP_RST;
      active  <= DISP_RST;
      pending <= 1'b0;
    end else begin
      if (disp.load) begin
        shadow <= in_data;
      end
      if (frame_last) begin
        if (disp.load) begin
          active <= in_data;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (disp.load) begin
        pending <= 1'b1;
      end
    end
  end

  // Free-running blink request, sampled into blink_phase only at frame boundaries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_req   <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      if (blink_cnt == LAST_BLINK) begin
        blink_cnt <= '0;
        blink_req <= ~blink_req;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (frame_last) begin
        blink_phase <= blink_req;
      end
    end
  end

  assign disp.seg        = seg_q;
  assign disp.seg_dp     = seg_dp_q;
  assign disp.dig_en     = dig_en_q;
  assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: 800 Hz clock, 4 digits, 8-cycle slots, 32-cycle frames.
// Stimulus pushes hand-derived per-cycle pin values; a negedge monitor pops and compares them.
// Covers reset, scan order, tear-free updates, boundary load, blink/blank/dp and mid-frame reset.
module tb_seven_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;
  int   tests = 0;
  int   fails = 0;
  int   t0 = 0;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    string      name;
  } exp_t;

  exp_t q[$];

  seven_seg_scan_if #(.DIGITS(4)) disp ();

  seven_seg_scan #(
    .CLK_HZ(800), .DIGITS(4), .SCAN_HZ(25), .DEAD(2), .BLINK_HZ(1),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .disp(disp)
  );

  always #5 clk = ~clk;

  // Absolute edge count since time zero; keys of the expectation queue.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] en, input logic [6:0] seg,
                      input logic dp, input logic ft, input string nm);
    exp_t e;
    e.cyc = c; e.en = en; e.seg = seg; e.dp = dp; e.ft = ft; e.name = nm;
    q.push_back(e);
  endtask

  // One full 32-cycle frame: glyph = {g3,g2,g1,g0} active-high, dark/dpon per digit.
  task automatic push_frame(input int base, input logic [27:0] glyph, input logic [3:0] dark,
                            input logic [3:0] dpon, input string nm);
    logic [6:0] g;
    logic [3:0] en;
    for (int d = 0; d < 4; d++) begin
      g  = glyph[7*d +: 7];
      en = 4'hF ^ (4'b0001 << d);
      for (int s = 0; s < 8; s++) begin
        if (s < 2)
          push(base + 8*d + s, 4'hF, 7'h7F, 1'b1, 1'b0, nm);
        else
          push(base + 8*d + s, en, dark[d] ? 7'h7F : ~g,
               (dpon[d] && !dark[d]) ? 1'b0 : 1'b1, (d == 3 && s == 7), nm);
      end
    end
  endtask

  task automatic at_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Load strobe sampled on edge n (cycle numbering from t0).
  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic [3:0] bk);
    at_cycle(t0 + n - 1);
    disp.value = v; disp.dp = dpv; disp.blank = bl; disp.blink = bk; disp.load = 1'b1;
    at_cycle(t0 + n);
    disp.load = 1'b0;
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s missed check at cyc=%0d (now %0d)", e.name, e.cyc, cyc);
      end else if (disp.dig_en !== e.en || disp.seg !== e.seg ||
                   disp.seg_dp !== e.dp || disp.frame_tick !== e.ft) begin
        fails++;
        $display("FAIL %s cyc=%0d got en=%b seg=%h dp=%b ft=%b want en=%b seg=%h dp=%b ft=%b",
                 e.name, e.cyc - t0, disp.dig_en, disp.seg, disp.seg_dp, disp.frame_tick,
                 e.en, e.seg, e.dp, e.ft);
      end
    end
  end

  initial begin
    int r;
    disp.value = '0; disp.dp = '0; disp.blank = 4'hF; disp.blink = '0; disp.load = 1'b0;

    push(1, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_hold");
    at_cycle(2);
    rst = 1'b0;
    t0  = 3;
    push_frame(t0, 28'h0, 4'hF, 4'h0, "reset_dark");

    push_frame(t0 + 32, {7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0, 4'h0, "scan_order");
    do_load(5, 16'h3210, 4'h0, 4'h0, 4'h0);

    push_frame(t0 + 64, {4{7'h71}}, 4'h0, 4'h0, "tear_next_frame");
    do_load(40, 16'hFFFF, 4'h0, 4'h0, 4'h0);

    push_frame(t0 + 96, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'h0, 4'h0, "boundary_load");
    do_load(95, 16'h4567, 4'h0, 4'h0, 4'h0);

    push_frame(t0 + 160, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b0010, 4'b0100, "attr_blank_dp");
    push_frame(t0 + 384, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b0010, 4'b0100, "blink_visible");
    push_frame(t0 + 416, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b0011, 4'b0100, "blink_dark");
    push_frame(t0 + 864, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b0010, 4'b0100, "blink_back");
    do_load(130, 16'h4567, 4'b0100, 4'b0010, 4'b0001);

    r = t0 + 941;
    push(r, 4'hF, 7'h7F, 1'b1, 1'b0, "mid_reset_edge");
    push_frame(r + 1, 28'h0, 4'hF, 4'h0, "post_reset_f0");
    push_frame(r + 33, 28'h0, 4'hF, 4'h0, "post_reset_f1");
    at_cycle(r - 1);
    rst = 1'b1;
    at_cycle(r);
    rst = 1'b0;

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
